// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, funct3 codes and access-legality helpers for the load/store unit
package lsu_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} lsu_state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lo);
    return (funct3 == F3_H || funct3 == F3_HU) ? lo[0] : (funct3 == F3_W) ? |lo : 1'b0;
  endfunction
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    return we ? !(funct3 inside {F3_B, F3_H, F3_W}) : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: pipeline request/response bus and word-addressed data memory bus of the load/store unit
interface lsu_if #(parameter int ADDR_W = 32, parameter int XLEN = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_fault;
  modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                  input req_ready, rsp_valid, rsp_rdata, rsp_fault);
  modport slave (input req_valid, req_we, req_funct3, req_addr, req_wdata,
                 output req_ready, rsp_valid, rsp_rdata, rsp_fault);
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 32, parameter int XLEN = 32);
  logic              mem_read_en;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_write_data;
  logic [XLEN-1:0]   mem_read_data;
  modport master (output mem_read_en, mem_write_en, mem_addr, mem_write_data, input mem_read_data);
  modport slave (input mem_read_en, mem_write_en, mem_addr, mem_write_data, output mem_read_data);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte/halfword lane extract-and-extend for loads and lane merge for narrow stores
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] mask;
  assign sh = {lo, 3'b000};
  assign lane = rdata >> sh;
  assign load_data = funct3 == F3_B  ? {{24{lane[7]}}, lane[7:0]} :
                     funct3 == F3_H  ? {{16{lane[15]}}, lane[15:0]} :
                     funct3 == F3_BU ? {24'b0, lane[7:0]} :
                     funct3 == F3_HU ? {16'b0, lane[15:0]} : rdata;
  assign mask = (funct3 == F3_H ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
  assign merged = (rdata & ~mask) | ((wdata << sh) & mask);
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit with alignment checks and read-modify-write narrow stores
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input logic clk,
  input logic rst_n,
  lsu_if.slave     req,
  lsu_mem_if.master mem
);
  lsu_state_t        state;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   wbuf;
  logic [XLEN-1:0]   rdata_q;
  logic              fault_q;
  logic              req_fault;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   merged;
  lsu_align u_align (
    .funct3(f3_q),
    .lo(addr_q[1:0]),
    .rdata(mem.mem_read_data),
    .wdata(wdata_q),
    .load_data(load_data),
    .merged(merged)
  );
  assign req_fault = is_illegal(req.req_we, req.req_funct3) | is_misaligned(req.req_funct3, req.req_addr[1:0]);
  assign req.req_ready = state == IDLE;
  assign req.rsp_valid = state == RESP;
  assign req.rsp_rdata = rdata_q;
  assign req.rsp_fault = fault_q;
  // memory enables decode straight from state so an async reset kills a write in flight
  assign mem.mem_read_en = state == LOAD || state == RMW_RD;
  assign mem.mem_write_en = state == WRITE;
  assign mem.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem.mem_write_data = wbuf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wbuf    <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req.req_valid) begin
          f3_q    <= req.req_funct3;
          addr_q  <= req.req_addr;
          wdata_q <= req.req_wdata;
          if (req_fault) begin
            fault_q <= 1'b1;
            rdata_q <= '0;
            state   <= RESP;
          end else if (!req.req_we) begin
            state <= LOAD;
          end else if (req.req_funct3 == F3_W) begin
            wbuf  <= req.req_wdata;
            state <= WRITE;
          end else begin
            state <= RMW_RD;
          end
        end
        LOAD: begin
          rdata_q <= load_data;
          fault_q <= 1'b0;
          state   <= RESP;
        end
        RMW_RD: begin
          wbuf  <= merged;
          state <= WRITE;
        end
        WRITE: begin
          rdata_q <= '0;
          fault_q <= 1'b0;
          state   <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the execute stage and the data memory model. Accepts one load or store request at a time, checks alignment, and drives the word-addressed, byte-enable-less data memory. Stores narrower than 32 bits are handled by read-modify-write. Returns sign- or zero-extended load data and a fault flag to the pipeline, which stalls while `req_ready` is low.

## Interface
- `ADDR_W`, 32: address width.
- `XLEN`, 32: data width. Only 32 is supported.
- `clk  in  1`: single clock. All state updates on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `req_valid  in  1`: request present.
- `req_ready  out  1`: unit idle and able to accept a request.
- `req_we  in  1`: 1 = store, 0 = load.
- `req_funct3  in  3`: RV32I load/store funct3.
- `req_addr  in  ADDR_W`: byte address.
- `req_wdata  in  XLEN`: store data, right-aligned.
- `rsp_valid  out  1`: one-cycle completion pulse.
- `rsp_rdata  out  XLEN`: extended load data. 0 for stores and faults.
- `rsp_fault  out  1`: misaligned access or illegal funct3. Valid with `rsp_valid`.
- `mem_read_en  out  1`, `mem_write_en  out  1`: memory controls.
- `mem_addr  out  ADDR_W`: word-aligned byte address, with `[1:0]` forced to 0.
- `mem_write_data  out  XLEN`: full word to write.
- `mem_read_data  in  XLEN`: asynchronous read data. It is only valid while `mem_read_en` is 1.

## Operation
- **funct3 encodings**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- **Fault conditions**
  - Illegal funct3.
  - Halfword access with `addr[0]` = 1.
  - Word access with `addr[1:0]` ≠ 0.
  - A faulting request performs no memory access.
- **FSM states**: IDLE, LOAD, RMW_RD, WRITE, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, latch `we`, `funct3`, `addr` and `wdata`, then branch:
    - fault → RESP;
    - load → LOAD;
    - SW → WRITE, with `wbuf = wdata`;
    - SB/SH → RMW_RD.
- **LOAD**
  - `mem_read_en` = 1.
  - Select the byte or halfword using `addr[1:0]`, extend it (sign for LB/LH, zero for LBU/LHU), register it into `rsp_rdata`.
  - Go to RESP.
- **RMW_RD**
  - `mem_read_en` = 1.
  - Form `wbuf` from `mem_read_data`, with the target byte lane (SB) or halfword lane (SH) replaced by the low bits of `wdata`.
  - Go to WRITE.
- **WRITE**
  - `mem_write_en` = 1 and `mem_write_data = wbuf`. The memory commits at the closing edge.
  - Go to RESP.
- **RESP**
  - `rsp_valid` = 1 and `rsp_fault` is driven.
  - Go to IDLE.
- **Response handshake**
  - There is no backpressure on the response.
  - `rsp_rdata` and `rsp_fault` hold their values until the next RESP.
- **Memory control outputs**
  - `mem_read_en` and `mem_write_en` are decoded from the state register. They are never both 1.
  - Both are 0 in IDLE and RESP.

## Timing
- **Reset**
  - State = IDLE, `req_ready` = 1 once reset is released.
  - All other outputs 0, including `rsp_valid`, `rsp_fault`, `rsp_rdata`, `mem_*_en`, `mem_addr` and `mem_write_data`.
- **Latency**, counted from the accept edge T (IDLE with `req_valid` = 1):
  - Load: `rsp_valid` in cycle T+2.
  - SW: write in cycle T+1, `rsp_valid` in T+2.
  - SB/SH: read in T+1, write in T+2, `rsp_valid` in T+3.
  - Fault: `rsp_valid` in T+1.
- **Back-to-back requests**: `req_ready` returns to 1 in the cycle after RESP, so the next accept is at the earliest one cycle after `rsp_valid`.
- **Reset mid-operation**
  - Asynchronous: `mem_write_en` drops immediately, so no partial or late write occurs.
  - The pending response is discarded.
- **Throughput**: at most one outstanding request. `req_*` inputs are ignored while `req_ready` = 0.

## Structure
- **Package `lsu_pkg`**
  - State enum `lsu_state_t`.
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Function `is_misaligned(funct3, addr[1:0])`.
- **Sub-module `lsu_align`** (purely combinational)
  - Load path: lane extract and extend.
  - Store path: lane merge.
  - Instantiated once, shared by LOAD and RMW_RD.
- **Top `lsu`**: FSM, request latches, `wbuf`, response registers.

## Test plan
- Memory word 0x100 = 0x8899AABB; LB, LBU, LH, LHU, LW at 0x100 → rsp_rdata 0xFFFFFFBB, 0x000000BB, 0xFFFFAABB, 0x0000AABB, 0x8899AABB; response 2 cycles after accept.
- Word 0x200 = 0x11223344; SB 0x55 at 0x202 → word becomes 0x11553344, `mem_write_en` high exactly one cycle, `rsp_valid` at T+3; SH 0xBEEF at 0x200 → 0x1155BEEF.
- SW 0xDEADBEEF at 0x300, then LW 0x300 → 0xDEADBEEF; `req_ready` low during the store.
- LH at 0x101, LW at 0x302, funct3 = 011 → `rsp_fault` = 1 at T+1, `mem_read_en` and `mem_write_en` never asserted, memory unchanged.
- Assert `rst_n` low during the WRITE cycle of an SB → `mem_write_en` drops asynchronously, target word unchanged, all outputs 0, `req_ready` = 1 after release.
- `req_valid` held high continuously with alternating loads and stores → each request accepted only in IDLE, exactly one `rsp_valid` per accepted request, results in order.
